// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared state encoding and NEC pulse windows for the IR decoder
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LEAD_LOW  = 3'd1,
    LEAD_HIGH = 3'd2,
    BIT_LOW   = 3'd3,
    BIT_HIGH  = 3'd4,
    CHECK     = 3'd5,
    ERR       = 3'd6
  } ir_state_t;

  localparam int DUR_W = 14;

  // All windows are in microseconds, inclusive on both ends.
  localparam logic [DUR_W-1:0] DUR_SAT       = 14'd16383;
  localparam logic [DUR_W-1:0] T_TIMEOUT     = 14'd10000;
  localparam logic [DUR_W-1:0] LEAD_LOW_MIN  = 14'd8000;
  localparam logic [DUR_W-1:0] LEAD_LOW_MAX  = 14'd10000;
  localparam logic [DUR_W-1:0] LEAD_HIGH_MIN = 14'd4000;
  localparam logic [DUR_W-1:0] LEAD_HIGH_MAX = 14'd5000;
  localparam logic [DUR_W-1:0] REP_HIGH_MIN  = 14'd2000;
  localparam logic [DUR_W-1:0] REP_HIGH_MAX  = 14'd2500;
  localparam logic [DUR_W-1:0] BIT_LOW_MIN   = 14'd400;
  localparam logic [DUR_W-1:0] BIT_LOW_MAX   = 14'd700;
  localparam logic [DUR_W-1:0] ZERO_HIGH_MIN = 14'd400;
  localparam logic [DUR_W-1:0] ZERO_HIGH_MAX = 14'd700;
  localparam logic [DUR_W-1:0] ONE_HIGH_MIN  = 14'd1400;
  localparam logic [DUR_W-1:0] ONE_HIGH_MAX  = 14'd1900;

  function automatic logic in_win(input logic [DUR_W-1:0] d,
                                  input logic [DUR_W-1:0] lo,
                                  input logic [DUR_W-1:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/ir_us_tick.sv
// rtl/ir_us_tick.sv - free-running prescaler giving a one-cycle strobe per microsecond
module ir_us_tick #(
  parameter int US_DIV = 50
) (
  input  logic Clk,
  input  logic rst_n,
  output logic us_tick
);

  localparam int CW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(US_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      us_tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt     <= '0;
      us_tick <= 1'b1;
    end else begin
      cnt     <= cnt + 1'b1;
      us_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/ir_nec_decoder.sv
// rtl/ir_nec_decoder.sv - NEC IR frame decoder: sync, pulse timing FSM, frame publish
module ir_nec_decoder
  import ir_pkg::*;
#(
  parameter int US_DIV     = 50,
  parameter int READY_CYC  = 1,
  parameter int CHECK_ADDR = 0
) (
  input  logic        Clk,
  input  logic        rst_n,
  input  logic        IRDA_RXD,
  output logic        IR_READY,
  output logic [31:0] IR_DATA,
  output logic        IR_REPEAT,
  output logic        IR_ERR
);

  localparam int RCW = (READY_CYC > 1) ? $clog2(READY_CYC) : 1;

  logic             sync1, sync2, sync3;
  logic             rise, fall, edge_any;
  logic             us_tick;
  logic [DUR_W-1:0] dur;
  logic             timeout;

  ir_state_t        state, state_n;
  logic [31:0]      sr;
  logic [4:0]       bit_cnt;
  logic [RCW-1:0]   ready_cnt;

  logic             shift_en, shift_val, clr_bits, rep_p, err_p, pass_p;
  logic             cmd_ok, addr_ok;

  ir_us_tick #(.US_DIV(US_DIV)) u_tick (
    .Clk     (Clk),
    .rst_n   (rst_n),
    .us_tick (us_tick)
  );

  // sync3 is the registered copy used for edge detection; all idle high.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= IRDA_RXD;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise     = ~sync3 & sync2;
  assign fall     = sync3 & ~sync2;
  assign edge_any = rise | fall;

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      dur <= '0;
    end else if (edge_any) begin
      dur <= '0;
    end else if (us_tick && (dur != DUR_SAT)) begin
      dur <= dur + 1'b1;
    end
  end

  assign timeout = (dur > T_TIMEOUT);

  assign cmd_ok  = (sr[23:16] == ~sr[31:24]);
  assign addr_ok = (CHECK_ADDR == 0) || (sr[7:0] == ~sr[15:8]);

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Each phase is judged on the edge that ends it, using the dur it accumulated.
  always_comb begin
    state_n   = state;
    shift_en  = 1'b0;
    shift_val = 1'b0;
    clr_bits  = 1'b0;
    rep_p     = 1'b0;
    err_p     = 1'b0;
    pass_p    = 1'b0;
    case (state)
      IDLE: begin
        if (fall) state_n = LEAD_LOW;
      end
      LEAD_LOW: begin
        if (rise) begin
          state_n = in_win(dur, LEAD_LOW_MIN, LEAD_LOW_MAX) ? LEAD_HIGH : ERR;
        end else if (timeout) begin
          state_n = ERR;
        end
      end
      LEAD_HIGH: begin
        if (fall) begin
          if (in_win(dur, LEAD_HIGH_MIN, LEAD_HIGH_MAX)) begin
            clr_bits = 1'b1;
            state_n  = BIT_LOW;
          end else if (in_win(dur, REP_HIGH_MIN, REP_HIGH_MAX)) begin
            rep_p   = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = ERR;
          end
        end else if (timeout) begin
          state_n = ERR;
        end
      end
      BIT_LOW: begin
        if (rise) begin
          state_n = in_win(dur, BIT_LOW_MIN, BIT_LOW_MAX) ? BIT_HIGH : ERR;
        end else if (timeout) begin
          state_n = ERR;
        end
      end
      BIT_HIGH: begin
        if (fall) begin
          if (in_win(dur, ZERO_HIGH_MIN, ZERO_HIGH_MAX)) begin
            shift_en  = 1'b1;
            shift_val = 1'b0;
          end else if (in_win(dur, ONE_HIGH_MIN, ONE_HIGH_MAX)) begin
            shift_en  = 1'b1;
            shift_val = 1'b1;
          end
          if (!shift_en)              state_n = ERR;
          else if (bit_cnt == 5'd31)  state_n = CHECK;
          else                        state_n = BIT_LOW;
        end else if (timeout) begin
          state_n = ERR;
        end
      end
      CHECK: begin
        if (cmd_ok && addr_ok) pass_p = 1'b1;
        else                   err_p  = 1'b1;
        state_n = IDLE;
      end
      ERR: begin
        err_p   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bits arrive LSB first, so each new bit enters at the top and walks down to bit 0.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (state == ERR) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clr_bits) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      sr      <= {shift_val, sr[31:1]};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      IR_DATA   <= '0;
      IR_REPEAT <= 1'b0;
      IR_ERR    <= 1'b0;
    end else begin
      IR_REPEAT <= rep_p;
      IR_ERR    <= err_p;
      if (pass_p) IR_DATA <= sr;
    end
  end

  // A new frame while READY is still high restarts the hold time.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      IR_READY  <= 1'b0;
      ready_cnt <= '0;
    end else if (pass_p) begin
      IR_READY  <= 1'b1;
      ready_cnt <= RCW'(READY_CYC - 1);
    end else if (IR_READY) begin
      if (ready_cnt == '0) IR_READY  <= 1'b0;
      else                 ready_cnt <= ready_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// tb/tb_ir_nec_decoder.sv - directed NEC frames with an event scoreboard
module tb_ir_nec_decoder;

  localparam int US = 5;
  localparam logic [1:0] EV_READY  = 2'd1;
  localparam logic [1:0] EV_REPEAT = 2'd2;
  localparam logic [1:0] EV_ERR    = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } ev_t;

  logic        Clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IRDA_RXD = 1'b1;
  logic        IR_READY;
  logic [31:0] IR_DATA;
  logic        IR_REPEAT;
  logic        IR_ERR;

  int  n_checks = 0;
  int  n_errors = 0;
  ev_t sb[$];
  ev_t mon_e;
  logic [1:0] mon_k;

  always #5 Clk = ~Clk;

  ir_nec_decoder #(.US_DIV(US), .READY_CYC(1), .CHECK_ADDR(0)) dut (
    .Clk       (Clk),
    .rst_n     (rst_n),
    .IRDA_RXD  (IRDA_RXD),
    .IR_READY  (IR_READY),
    .IR_DATA   (IR_DATA),
    .IR_REPEAT (IR_REPEAT),
    .IR_ERR    (IR_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] k, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  // Every output pulse must match the next queued expectation.
  always @(negedge Clk) begin
    if (rst_n === 1'b1 && (IR_READY || IR_REPEAT || IR_ERR)) begin
      mon_k = IR_READY ? EV_READY : (IR_REPEAT ? EV_REPEAT : EV_ERR);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, mon_k}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("event_kind", {30'd0, mon_k}, {30'd0, mon_e.kind});
        chk("event_data", IR_DATA, mon_e.data);
      end
    end
  end

  task automatic hold(input logic lvl, input int us);
    IRDA_RXD = lvl;
    repeat (us * US) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [31:0] w, input int nbits, input bit measure);
    hold(1'b0, 8500);
    hold(1'b1, 4250);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, 450);
      hold(1'b1, w[i] ? 1450 : 450);
    end
    if (nbits == 32) begin
      if (measure) begin
        IRDA_RXD = 1'b0;
        repeat (3) @(posedge Clk);
        #1 chk("ready_edge3", {31'd0, IR_READY}, 32'd0);
        @(posedge Clk);
        #1 chk("ready_edge4", {31'd0, IR_READY}, 32'd1);
        chk("data_edge4", IR_DATA, w);
        @(negedge Clk);
        hold(1'b0, 449);
      end else begin
        hold(1'b0, 450);
      end
      hold(1'b1, 2000);
    end
  endtask

  initial begin
    int  k;
    bit  found;

    // 1. reset state and quiet idle line
    repeat (4) @(negedge Clk);
    chk("rst_data", IR_DATA, 32'd0);
    chk("rst_ready", {31'd0, IR_READY}, 32'd0);
    chk("rst_repeat", {31'd0, IR_REPEAT}, 32'd0);
    chk("rst_err", {31'd0, IR_ERR}, 32'd0);
    rst_n = 1'b1;
    repeat (100) @(negedge Clk);
    chk("idle_data", IR_DATA, 32'd0);
    chk("idle_ready", {31'd0, IR_READY}, 32'd0);
    chk("idle_repeat", {31'd0, IR_REPEAT}, 32'd0);
    chk("idle_err", {31'd0, IR_ERR}, 32'd0);
    hold(1'b1, 200);

    // 2. valid frame addr=00 cmd=05
    push_ev(EV_READY, 32'hFA05FF00);
    send_frame(32'hFA05FF00, 32, 1'b1);
    chk("keycode", {24'd0, IR_DATA[23:16]}, 32'h05);

    // 3. bad command complement
    push_ev(EV_ERR, 32'hFA05FF00);
    send_frame(32'hFB05FF00, 32, 1'b0);
    chk("data_after_bad", IR_DATA, 32'hFA05FF00);

    // 4. repeat code
    push_ev(EV_REPEAT, 32'hFA05FF00);
    hold(1'b0, 9000);
    hold(1'b1, 2250);
    hold(1'b0, 560);
    hold(1'b1, 2000);
    chk("data_after_repeat", IR_DATA, 32'hFA05FF00);

    // 5. leader then stuck high: timeout
    push_ev(EV_ERR, 32'hFA05FF00);
    hold(1'b0, 8500);
    IRDA_RXD = 1'b1;
    found = 1'b0;
    k = 0;
    for (int c = 1; c <= 20000 * US && !found; c++) begin
      @(posedge Clk);
      #1;
      if (IR_ERR) begin
        found = 1'b1;
        k = c;
      end
    end
    chk("timeout_seen", {31'd0, found}, 32'd1);
    chk("timeout_window", {31'd0, (k >= 50006 && k <= 50011)}, 32'd1);
    @(negedge Clk);
    repeat (20000 * US - k) @(negedge Clk);
    chk("data_after_timeout", IR_DATA, 32'hFA05FF00);
    push_ev(EV_READY, 32'hE817FF00);
    send_frame(32'hE817FF00, 32, 1'b0);
    chk("data_cmd17", IR_DATA, 32'hE817FF00);

    // 6. reset mid-frame, then a clean frame
    send_frame(32'hE817FF00, 16, 1'b0);
    rst_n = 1'b0;
    repeat (5) @(negedge Clk);
    chk("midrst_data", IR_DATA, 32'd0);
    chk("midrst_ready", {31'd0, IR_READY}, 32'd0);
    chk("midrst_err", {31'd0, IR_ERR}, 32'd0);
    rst_n = 1'b1;
    hold(1'b1, 1000);
    chk("postrst_data", IR_DATA, 32'd0);
    push_ev(EV_READY, 32'hEE11FF00);
    send_frame(32'hEE11FF00, 32, 1'b0);
    chk("data_cmd11", IR_DATA, 32'hEE11FF00);

    hold(1'b1, 500);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
